// File: rtl/ks_pkg.sv
// Shared types and default constants for the Karplus-Strong voice and its note sequencer.
package ks_pkg;

    localparam int KS_DATA_WIDTH = 8;
    localparam int KS_MAX_LENGTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PLUCK = 2'd2,
        WAIT  = 2'd3
    } ks_state_e;

    // One pattern step as stored at the default voice width.
    typedef struct packed {
        logic                     rest;
        logic [KS_DATA_WIDTH-1:0] period;
    } ks_entry_t;

endpackage

// File: rtl/ks_note_sequencer_if.sv
// Pattern-write bus from the register/control side into the note sequencer.
interface ks_note_sequencer_if #(
    parameter int STEPS      = 8,
    parameter int DATA_WIDTH = 8
);
    localparam int AW = $clog2(STEPS);

    // wr_en_i is the valid; the sequencer is always ready, so every clock with wr_en_i high commits one write.
    logic                  wr_en_i;
    logic [AW-1:0]         wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_period_i;
    logic                  wr_rest_i;

    modport master (
        output wr_en_i,
        output wr_addr_i,
        output wr_period_i,
        output wr_rest_i
    );

    modport slave (
        input wr_en_i,
        input wr_addr_i,
        input wr_period_i,
        input wr_rest_i
    );

endinterface

// File: rtl/ks_pattern_mem.sv
// STEPS-deep pattern register file: {rest, period} per step, synchronous write, combinational read.
module ks_pattern_mem #(
    parameter int STEPS      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LENGTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [DATA_WIDTH:0]        wr_data,
    input  logic [$clog2(STEPS)-1:0]   rd_addr,
    output logic [DATA_WIDTH:0]        rd_data
);

    // Every step comes out of reset as a rest at the longest legal period.
    localparam logic [DATA_WIDTH:0] RESET_ENTRY = {1'b1, DATA_WIDTH'(MAX_LENGTH)};

    logic [DATA_WIDTH:0] mem_q [STEPS];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ks_note_sequencer.sv
// Note sequencer: walks the note/rest pattern at a sample-tick tempo and drives period/pluck to the string voice.
module ks_note_sequencer
    import ks_pkg::*;
#(
    parameter int STEPS       = 8,
    parameter int DATA_WIDTH  = KS_DATA_WIDTH,
    parameter int MAX_LENGTH  = KS_MAX_LENGTH,
    parameter int TEMPO_WIDTH = 16,
    parameter int PLUCK_LEN   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       enable_i,
    input  logic                       sample_tick_i,
    input  logic [TEMPO_WIDTH-1:0]     tempo_i,
    input  logic [$clog2(STEPS)-1:0]   last_step_i,
    ks_note_sequencer_if.slave         wr,
    output logic [DATA_WIDTH-1:0]      period_o,
    output logic                       pluck_o,
    output logic [$clog2(STEPS)-1:0]   step_o,
    output logic                       wrap_o,
    output logic                       busy_o,
    output ks_state_e                  state_o
);

    localparam int AW = $clog2(STEPS);
    localparam int PW = $clog2(PLUCK_LEN);

    localparam logic [DATA_WIDTH-1:0]  MAX_PERIOD = DATA_WIDTH'(MAX_LENGTH);
    localparam logic [TEMPO_WIDTH-1:0] TEMPO_ONE  = TEMPO_WIDTH'(1);
    localparam logic [AW-1:0]          STEP_ONE   = AW'(1);
    localparam logic [PW-1:0]          PCNT_ONE   = PW'(1);
    localparam logic [PW-1:0]          PLUCK_LAST = PW'(PLUCK_LEN - 1);

    ks_state_e              state_q, state_d;
    logic [AW-1:0]          step_q, step_d;
    logic [TEMPO_WIDTH-1:0] tempo_q, tempo_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [DATA_WIDTH-1:0]  period_q, period_d;
    logic                   note_q, note_d;
    logic                   wrap_q, wrap_d;
    logic                   pluck_q;
    logic                   busy_q;

    logic [DATA_WIDTH:0]    rd_entry;
    logic                   rd_rest;
    logic [DATA_WIDTH-1:0]  rd_period;

    // The step is fetched as the FSM enters LOAD, so period_o is already
    // stable for the whole LOAD clock before pluck_o rises.
    ks_pattern_mem #(
        .STEPS      (STEPS),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LENGTH (MAX_LENGTH)
    ) u_pattern_mem (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .wr_en   (wr.wr_en_i),
        .wr_addr (wr.wr_addr_i),
        .wr_data ({wr.wr_rest_i, wr.wr_period_i}),
        .rd_addr (step_d),
        .rd_data (rd_entry)
    );

    assign rd_rest   = rd_entry[DATA_WIDTH];
    assign rd_period = rd_entry[DATA_WIDTH-1:0];

    // Sequencing: state, step index, tempo count and pluck length.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tempo_d = tempo_q;
        pcnt_d  = pcnt_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = LOAD;
            end
            LOAD: begin
                tempo_d = (tempo_i == '0) ? TEMPO_ONE : tempo_i;
                if (note_q) begin
                    state_d = PLUCK;
                    pcnt_d  = PLUCK_LAST;
                end else begin
                    state_d = WAIT;
                end
            end
            PLUCK: begin
                if (sample_tick_i && (tempo_q != '0)) tempo_d = tempo_q - TEMPO_ONE;
                if (pcnt_q == '0) state_d = WAIT;
                else              pcnt_d  = pcnt_q - PCNT_ONE;
            end
            WAIT: begin
                if (tempo_q == '0) begin
                    state_d = LOAD;
                    // >= so that lowering last_step_i below the current step still wraps.
                    if (step_q >= last_step_i) begin
                        step_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        step_d = step_q + STEP_ONE;
                    end
                end else if (sample_tick_i) begin
                    tempo_d = tempo_q - TEMPO_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable_i) begin
            state_d = IDLE;
            step_d  = '0;
            wrap_d  = 1'b0;
            tempo_d = '0;
            pcnt_d  = '0;
        end
    end

    // Step fetch: rests and zero periods leave period_o untouched.
    always_comb begin
        period_d = period_q;
        note_d   = note_q;
        if (state_d == LOAD) begin
            note_d = !rd_rest && (rd_period != '0);
            if (note_d) period_d = (rd_period > MAX_PERIOD) ? MAX_PERIOD : rd_period;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            tempo_q  <= '0;
            pcnt_q   <= '0;
            period_q <= MAX_PERIOD;
            note_q   <= 1'b0;
            wrap_q   <= 1'b0;
            pluck_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tempo_q  <= tempo_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            note_q   <= note_d;
            wrap_q   <= wrap_d;
            pluck_q  <= (state_d == PLUCK);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign period_o = period_q;
    assign pluck_o  = pluck_q;
    assign step_o   = step_q;
    assign wrap_o   = wrap_q;
    assign busy_o   = busy_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer: hand-computed pluck timing, rests, clamping, disable/reset and write collision.
module tb_ks_note_sequencer;
    import ks_pkg::*;

    localparam int STEPS = 8;
    localparam int DW    = 8;
    localparam int TW    = 16;
    localparam int AW    = 3;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            enable_i      = 1'b0;
    logic            sample_tick_i = 1'b0;
    logic [TW-1:0]   tempo_i       = '0;
    logic [AW-1:0]   last_step_i   = '0;
    logic [DW-1:0]   period_o;
    logic            pluck_o;
    logic [AW-1:0]   step_o;
    logic            wrap_o;
    logic            busy_o;
    ks_state_e       state_o;

    ks_note_sequencer_if #(.STEPS(STEPS), .DATA_WIDTH(DW)) wr_if ();

    ks_note_sequencer #(
        .STEPS(STEPS), .DATA_WIDTH(DW), .MAX_LENGTH(32), .TEMPO_WIDTH(TW), .PLUCK_LEN(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .sample_tick_i (sample_tick_i),
        .tempo_i       (tempo_i),
        .last_step_i   (last_step_i),
        .wr            (wr_if),
        .period_o      (period_o),
        .pluck_o       (pluck_o),
        .step_o        (step_o),
        .wrap_o        (wrap_o),
        .busy_o        (busy_o),
        .state_o       (state_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int tick_div = 0;
    int ph       = 0;
    logic [AW+DW-1:0] exp_q[$];   // {step, period} expected at each pluck rise

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
        ph++;
        sample_tick_i = (tick_div != 0) && (((ph + 1) % tick_div) == 0);
    endtask

    task automatic start_ticks(input int div);
        tick_div      = div;
        ph            = 0;
        sample_tick_i = (div != 0) && ((1 % div) == 0);
    endtask

    task automatic write_entry(input int addr, input logic rest, input int period);
        wr_if.wr_en_i     = 1'b1;
        wr_if.wr_addr_i   = AW'(addr);
        wr_if.wr_rest_i   = rest;
        wr_if.wr_period_i = DW'(period);
        cyc();
        wr_if.wr_en_i     = 1'b0;
    endtask

    task automatic go_idle();
        enable_i = 1'b0;
        start_ticks(0);
        cyc();
    endtask

    task automatic run_rises(input string tag, input int budget, input bit chk_hold);
        logic prev;
        prev = pluck_o;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            cyc();
            if (pluck_o && !prev) check(tag, {step_o, period_o}, exp_q.pop_front());
            if (chk_hold && busy_o && (step_o == 3'd1 || step_o == 3'd2)) check({tag, "_hold16"}, period_o, 16);
            prev = pluck_o;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [13:0] exp_pluck_v;
        logic [13:0] exp_wrap_v;
        bit          found;

        wr_if.wr_en_i     = 1'b0;
        wr_if.wr_addr_i   = '0;
        wr_if.wr_rest_i   = 1'b0;
        wr_if.wr_period_i = '0;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_period", period_o, 32);
        check("rst_pluck", pluck_o, 0);
        check("rst_step", step_o, 0);
        check("rst_wrap", wrap_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_state", state_o, IDLE);
        rst_n = 1'b1;
        cyc();

        // Single note, tempo 3, tick every 4 clocks
        write_entry(0, 1'b0, 20);
        last_step_i = 3'd0;
        tempo_i     = 16'd3;
        enable_i    = 1'b1;
        start_ticks(4);
        exp_pluck_v = 14'b10000000011110;
        exp_wrap_v  = 14'b01000000000000;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            check($sformatf("t1_pluck_%0d", k), pluck_o, exp_pluck_v[k-1]);
            check($sformatf("t1_wrap_%0d", k), wrap_o, exp_wrap_v[k-1]);
            if (k == 1) begin
                check("t1_load_state", state_o, LOAD);
                check("t1_period_before_pluck", period_o, 20);
            end
        end

        // Rests and period 0 hold period_o; only steps 0 and 3 pluck
        go_idle();
        check("t2_idle_state", state_o, IDLE);
        check("t2_idle_busy", busy_o, 0);
        write_entry(0, 1'b0, 16);
        write_entry(1, 1'b1, 10);
        write_entry(2, 1'b0, 0);
        write_entry(3, 1'b0, 24);
        last_step_i = 3'd3;
        tempo_i     = 16'd1;
        enable_i    = 1'b1;
        start_ticks(1);
        exp_q.push_back({3'd0, 8'd16});
        exp_q.push_back({3'd3, 8'd24});
        exp_q.push_back({3'd0, 8'd16});
        exp_q.push_back({3'd3, 8'd24});
        run_rises("t2_rise", 120, 1'b1);

        // Reset asserted mid-pluck (at step 3) clears outputs without a clock edge
        check("t5_pre_rst_pluck", pluck_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_pluck", pluck_o, 0);
        check("t5_rst_period", period_o, 32);
        check("t5_rst_step", step_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_state", state_o, IDLE);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        cyc();
        cyc();
        check("t5_memrst_state", state_o, WAIT);
        check("t5_memrst_pluck", pluck_o, 0);

        // Write collision in LOAD, then shrinking last_step
        go_idle();
        write_entry(0, 1'b0, 10);
        write_entry(1, 1'b0, 11);
        write_entry(2, 1'b0, 12);
        write_entry(3, 1'b0, 13);
        last_step_i = 3'd3;
        tempo_i     = 16'd1;
        enable_i    = 1'b1;
        start_ticks(1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            cyc();
            if (state_o == LOAD && step_o == 3'd2) found = 1'b1;
        end
        check("t6_reach_load2", found, 1);
        wr_if.wr_en_i     = 1'b1;
        wr_if.wr_addr_i   = 3'd2;
        wr_if.wr_rest_i   = 1'b0;
        wr_if.wr_period_i = 8'd30;
        cyc();
        wr_if.wr_en_i     = 1'b0;
        check("t6_collide_pluck", pluck_o, 1);
        check("t6_collide_old_period", period_o, 12);
        exp_q.push_back({3'd3, 8'd13});
        exp_q.push_back({3'd0, 8'd10});
        exp_q.push_back({3'd1, 8'd11});
        exp_q.push_back({3'd2, 8'd30});
        run_rises("t6_new_period", 100, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc();
            if (step_o == 3'd3) found = 1'b1;
        end
        check("t6_reach_step3", found, 1);
        last_step_i = 3'd1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc();
            if (wrap_o) found = 1'b1;
        end
        check("t6_shrink_wrap", found, 1);
        check("t6_shrink_step", step_o, 0);
        exp_q.push_back({3'd0, 8'd10});
        exp_q.push_back({3'd1, 8'd11});
        run_rises("t6_short_loop", 60, 1'b0);

        // Disable during PLUCK at step 1, then restart at step 0
        enable_i = 1'b0;
        cyc();
        check("t5_dis_pluck", pluck_o, 0);
        check("t5_dis_step", step_o, 0);
        check("t5_dis_busy", busy_o, 0);
        check("t5_dis_state", state_o, IDLE);
        check("t5_dis_period_held", period_o, 11);
        enable_i = 1'b1;
        cyc();
        check("t5_reen_state", state_o, LOAD);
        check("t5_reen_period", period_o, 10);
        check("t5_reen_pluck_low", pluck_o, 0);
        cyc();
        check("t5_reen_pluck_high", pluck_o, 1);

        // Clamp of an over-long period and tempo 0 treated as 1
        go_idle();
        write_entry(0, 1'b0, 200);
        last_step_i = 3'd0;
        tempo_i     = 16'd0;
        enable_i    = 1'b1;
        cyc();
        check("t3_clamp_state", state_o, LOAD);
        check("t3_clamp_period", period_o, 32);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("t3_pluck_%0d", k), pluck_o, 1);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("t3_wait_state_%0d", k), state_o, WAIT);
            check($sformatf("t3_wait_wrap_%0d", k), wrap_o, 0);
        end
        sample_tick_i = 1'b1;
        cyc();
        check("t3_after_tick_state", state_o, WAIT);
        cyc();
        check("t3_advance_state", state_o, LOAD);
        check("t3_advance_wrap", wrap_o, 1);

        // Tempo shorter than the pluck: full 4-clock pulse, low gap between pulses
        go_idle();
        write_entry(0, 1'b0, 18);
        last_step_i = 3'd0;
        tempo_i     = 16'd1;
        enable_i    = 1'b1;
        start_ticks(1);
        exp_pluck_v = 14'b10011110011110;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            check($sformatf("t4_pluck_%0d", k), pluck_o, exp_pluck_v[k-1]);
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
